wb_dma_ch_prog: RTL and testbench

Channel programming sequencer for the wb_dma register file. It accepts channel programs from a local command port and programs them into the DMA register file as a Wishbone master, one write cycle at a time. It also services the DMA interrupt line by reading the interrupt source and per-channel CSR registers, then reports completions. It sits between the control logic and the DMA slave port (wb0s side), replacing software register programming.

---
 rtl/wb_dma_ch_prog_pkg.sv | 26 ++
 rtl/wb_dma_ch_prog_wbm.sv | 67 ++++++
 rtl/wb_dma_ch_prog.sv | 197 +++++++++++++++++++
 tb/tb_wb_dma_ch_prog.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_ch_prog_pkg.sv
// Shared definitions for the wb_dma channel programming sequencer:
// sequencer states, DMA register-file offsets and the channel enable bit.
package wb_dma_ch_prog_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SZ,
    S_W_A0,
    S_W_A1,
    S_W_CSR,
    S_R_INT,
    S_R_CSR,
    S_REPORT
  } state_e;

  localparam logic [31:0] INT_SRC_A = 32'h0000_000C;
  localparam logic [31:0] CH_BASE   = 32'h0000_0020;
  localparam logic [31:0] CH_STRIDE = 32'h0000_0020;
  localparam logic [31:0] CSR_OFF   = 32'h0000_0000;
  localparam logic [31:0] SZ_OFF    = 32'h0000_0004;
  localparam logic [31:0] A0_OFF    = 32'h0000_0008;
  localparam logic [31:0] A1_OFF    = 32'h0000_0010;

  localparam int CH_EN_BIT = 0;

endpackage

// File: rtl/wb_dma_ch_prog_wbm.sv
// Single-access Wishbone classic master: a one-cycle req opens CYC/STB, which stay up until ACK/ERR.
// Request fields are held stable by the requester; done/err/rdat are registered one cycle after the response.
module wb_dma_ch_prog_wbm (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdat_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdat_q;
  logic        cyc;

  // Both inputs are registers, so CYC starts the cycle after the request is issued.
  assign cyc      = req_i | busy_q;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = we_i;
  assign wb_sel_o = cyc ? 4'hF : 4'h0;
  assign wb_adr_o = adr_i;
  assign wb_dat_o = wdat_i;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdat_o   = rdat_q;

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cyc) begin
        if (wb_err_i) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end else if (wb_ack_i) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          rdat_q <= wb_dat_i;
        end else begin
          busy_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_dma_ch_prog.sv
// Programs wb_dma channels (SZ, A0, A1, then CSR) from a command port and services INTA by reading
// INT_SRC_A and each flagged channel CSR, reporting completions lowest channel first.
module wb_dma_ch_prog
  import wb_dma_ch_prog_pkg::*;
#(
  parameter logic [31:0] RF_BASE  = 32'h0000_0000,
  parameter int          CH_COUNT = 31
) (
  input  logic        clk,
  input  logic        rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_ch,
  input  logic [31:0] cmd_sz,
  input  logic [31:0] cmd_a0,
  input  logic [31:0] cmd_a1,
  input  logic [31:0] cmd_csr,
  input  logic        inta_i,
  output logic        done_valid,
  output logic [4:0]  done_ch,
  output logic [31:0] done_csr,
  output logic        bus_err,
  output logic        cmd_rej
);

  localparam logic [31:0] CH_MASK = (32'h1 << CH_COUNT) - 32'h1;
  localparam logic [31:0] CH_EN   = 32'h1 << CH_EN_BIT;

  state_e      state_q;
  logic        req_q, we_q, rdy_en_q;
  logic [31:0] adr_q, wdat_q, a0_q, a1_q, csr_q, mask_q;
  logic [4:0]  ch_q;
  logic        done_valid_q, bus_err_q, cmd_rej_q;
  logic [4:0]  done_ch_q;
  logic [31:0] done_csr_q;
  logic        bus_done, bus_fail;
  logic [31:0] bus_rdat, int_mask, mask_left;

  function automatic logic [31:0] ch_adr(input logic [4:0] ch, input logic [31:0] off);
    return RF_BASE + CH_BASE + CH_STRIDE * {27'd0, ch} + off;
  endfunction

  function automatic logic [4:0] lsb_idx(input logic [31:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign int_mask   = bus_rdat & CH_MASK;
  assign mask_left  = mask_q & ~(32'h1 << ch_q);
  // rdy_en_q holds cmd_ready low through reset and releases it one cycle after.
  assign cmd_ready  = rdy_en_q && (state_q == S_IDLE) && !inta_i;
  assign done_valid = done_valid_q;
  assign done_ch    = done_ch_q;
  assign done_csr   = done_csr_q;
  assign bus_err    = bus_err_q;
  assign cmd_rej    = cmd_rej_q;

  wb_dma_ch_prog_wbm u_wbm (
    .clk      (clk),
    .rst_i    (rst_i),
    .req_i    (req_q),
    .we_i     (we_q),
    .adr_i    (adr_q),
    .wdat_i   (wdat_q),
    .done_o   (bus_done),
    .err_o    (bus_fail),
    .rdat_o   (bus_rdat),
    .wb_cyc_o (wbm_cyc_o),
    .wb_stb_o (wbm_stb_o),
    .wb_we_o  (wbm_we_o),
    .wb_sel_o (wbm_sel_o),
    .wb_adr_o (wbm_adr_o),
    .wb_dat_o (wbm_dat_o),
    .wb_dat_i (wbm_dat_i),
    .wb_ack_i (wbm_ack_i),
    .wb_err_i (wbm_err_i)
  );

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      rdy_en_q     <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      a0_q         <= '0;
      a1_q         <= '0;
      csr_q        <= '0;
      mask_q       <= '0;
      ch_q         <= '0;
      done_valid_q <= 1'b0;
      done_ch_q    <= '0;
      done_csr_q   <= '0;
      bus_err_q    <= 1'b0;
      cmd_rej_q    <= 1'b0;
    end else begin
      req_q        <= 1'b0;
      done_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cmd_rej_q    <= 1'b0;
      rdy_en_q     <= 1'b1;
      // An error drops the whole sequence; CSR is last, so a half-written channel stays disabled.
      if (bus_done && bus_fail) begin
        bus_err_q <= 1'b1;
        state_q   <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (inta_i) begin
              state_q <= S_R_INT;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              adr_q   <= RF_BASE + INT_SRC_A;
              wdat_q  <= '0;
            end else if (cmd_valid && rdy_en_q) begin
              if (int'(cmd_ch) >= CH_COUNT) begin
                cmd_rej_q <= 1'b1;
              end else begin
                ch_q    <= cmd_ch;
                a0_q    <= cmd_a0;
                a1_q    <= cmd_a1;
                csr_q   <= cmd_csr | CH_EN;
                state_q <= S_W_SZ;
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                adr_q   <= ch_adr(cmd_ch, SZ_OFF);
                wdat_q  <= cmd_sz;
              end
            end
          end
          S_W_SZ: if (bus_done) begin
            state_q <= S_W_A0;
            req_q   <= 1'b1;
            adr_q   <= ch_adr(ch_q, A0_OFF);
            wdat_q  <= a0_q;
          end
          S_W_A0: if (bus_done) begin
            state_q <= S_W_A1;
            req_q   <= 1'b1;
            adr_q   <= ch_adr(ch_q, A1_OFF);
            wdat_q  <= a1_q;
          end
          S_W_A1: if (bus_done) begin
            state_q <= S_W_CSR;
            req_q   <= 1'b1;
            adr_q   <= ch_adr(ch_q, CSR_OFF);
            wdat_q  <= csr_q;
          end
          S_W_CSR: if (bus_done) state_q <= S_IDLE;
          S_R_INT: if (bus_done) begin
            if (int_mask == '0) begin
              state_q <= S_IDLE;
            end else begin
              mask_q  <= int_mask;
              ch_q    <= lsb_idx(int_mask);
              state_q <= S_R_CSR;
              req_q   <= 1'b1;
              adr_q   <= ch_adr(lsb_idx(int_mask), CSR_OFF);
            end
          end
          S_R_CSR: if (bus_done) state_q <= S_REPORT;
          S_REPORT: begin
            done_valid_q <= 1'b1;
            done_ch_q    <= ch_q;
            done_csr_q   <= bus_rdat;
            mask_q       <= mask_left;
            req_q        <= 1'b1;
            if (mask_left != '0) begin
              ch_q    <= lsb_idx(mask_left);
              adr_q   <= ch_adr(lsb_idx(mask_left), CSR_OFF);
              state_q <= S_R_CSR;
            end else begin
              adr_q   <= RF_BASE + INT_SRC_A;
              state_q <= S_R_INT;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_dma_ch_prog.sv
// Bench for wb_dma_ch_prog: a Wishbone slave model with programmable wait/error, and a scoreboard
// of expected bus accesses and completions that a negedge monitor pops and compares.
module tb_wb_dma_ch_prog;

  logic        clk;
  logic        rst_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_ch;
  logic [31:0] cmd_sz, cmd_a0, cmd_a1, cmd_csr;
  logic        inta_i;
  logic        done_valid;
  logic [4:0]  done_ch;
  logic [31:0] done_csr;
  logic        bus_err, cmd_rej;

  wb_dma_ch_prog #(.RF_BASE(32'h0), .CH_COUNT(31)) dut (
    .clk(clk), .rst_i(rst_i),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_sz(cmd_sz),
    .cmd_a0(cmd_a0), .cmd_a1(cmd_a1), .cmd_csr(cmd_csr), .inta_i(inta_i),
    .done_valid(done_valid), .done_ch(done_ch), .done_csr(done_csr),
    .bus_err(bus_err), .cmd_rej(cmd_rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} acc_t;
  typedef struct packed {logic [4:0] ch; logic [31:0] csr;} dn_t;
  acc_t exp_acc[$];
  dn_t  exp_dn[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_w(input logic [31:0] adr, input logic [31:0] dat);
    exp_acc.push_back({1'b1, adr, dat});
  endtask

  task automatic exp_r(input logic [31:0] adr);
    exp_acc.push_back({1'b0, adr, 32'h0});
  endtask

  // Slave model: INT_SRC_A reads come from a table; channel CSR reads return 0xA5 in the top byte plus the channel number.
  int          ack_dly = 0;
  int          acc_n = 0;
  int          err_at = -1;
  int          wcnt = 0;
  int          int_zero_cnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] int_tab [0:7];
  logic [2:0]  int_idx = 3'd0;
  logic [4:0]  rd_ch;
  logic        resp;

  assign rd_ch     = wbm_adr_o[9:5] - 5'd1;
  assign resp      = wbm_cyc_o && wbm_stb_o && (wcnt >= ack_dly);
  assign wbm_err_i = resp && (acc_n == err_at);
  assign wbm_ack_i = (resp && (acc_n != err_at)) || force_ack;
  assign wbm_dat_i = (wbm_adr_o == 32'h0C) ? int_tab[int_idx] : {8'hA5, 19'd0, rd_ch};

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
      wcnt  <= 0;
      acc_n <= acc_n + 1;
      if (!wbm_we_o && wbm_adr_o == 32'h0C) begin
        int_idx <= int_idx + 3'd1;
        if (int_tab[int_idx] == 32'h0) int_zero_cnt <= int_zero_cnt + 1;
      end
    end else if (wbm_cyc_o && wbm_stb_o) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  int n_err = 0;
  int n_rej = 0;

  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o) begin
      if (exp_acc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access actual adr=%h we=%b expected no access", wbm_adr_o, wbm_we_o);
      end else begin
        chk("bus_adr", wbm_adr_o, exp_acc[0].adr);
        chk("bus_we", 32'(wbm_we_o), 32'(exp_acc[0].we));
        chk("bus_sel", 32'(wbm_sel_o), 32'hF);
        if (wbm_ack_i || wbm_err_i) begin
          if (exp_acc[0].we) chk("bus_wdat", wbm_dat_o, exp_acc[0].dat);
          void'(exp_acc.pop_front());
        end
      end
    end
    if (done_valid) begin
      if (exp_dn.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual ch=%0d csr=%h expected none", done_ch, done_csr);
      end else begin
        chk("done_ch", 32'(done_ch), 32'(exp_dn[0].ch));
        chk("done_csr", done_csr, exp_dn[0].csr);
        void'(exp_dn.pop_front());
      end
    end
    if (bus_err) n_err++;
    if (cmd_rej) n_rej++;
  end

  task automatic do_cmd(input logic [4:0] ch, input logic [31:0] sz, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [31:0] csr);
    int g;
    cmd_ch = ch; cmd_sz = sz; cmd_a0 = a0; cmd_a1 = a1; cmd_csr = csr;
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_acc.size() != 0 || exp_dn.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 32'(exp_acc.size() + exp_dn.size()), 32'h0);
  endtask

  // Drops inta_i once the slave has returned a zero INT_SRC_A read.
  task automatic wait_int_clear(input int z);
    int g;
    g = 0;
    while (int_zero_cnt == z && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("int_src_zero_read", 32'(int_zero_cnt - z), 32'h1);
    inta_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int z;
    int a;
    int r;
    rst_i = 1'b0; cmd_valid = 1'b0; inta_i = 1'b0;
    cmd_ch = '0; cmd_sz = '0; cmd_a0 = '0; cmd_a1 = '0; cmd_csr = '0;
    for (int i = 0; i < 8; i++) int_tab[i] = 32'h0;
    int_tab[0] = 32'h8000_0012;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, cmd_ready, done_valid, bus_err, cmd_rej}), 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_done_fields", 32'(done_ch) | done_csr, 32'h0);
    rst_i = 1'b1;
    #1 chk("ready_before_release_edge", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'h1);

    // Channel 2 program, zero-wait slave.
    exp_w(32'h64, 32'h40); exp_w(32'h68, 32'h1000); exp_w(32'h70, 32'h2000); exp_w(32'h60, 32'h1);
    do_cmd(5'd2, 32'h40, 32'h1000, 32'h2000, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) chk("first_stb_t1", 32'(wbm_stb_o), 32'h1);
      if (k == 8) chk("ready_t8", 32'(cmd_ready), 32'h0);
      if (k == 9) chk("ready_t9", 32'(cmd_ready), 32'h1);
    end
    drain();

    // Interrupt: source 0x8000_0012 masks to channels 1 and 4.
    exp_r(32'h0C); exp_r(32'h40); exp_r(32'hA0); exp_r(32'h0C);
    exp_dn.push_back({5'd1, 32'hA500_0001});
    exp_dn.push_back({5'd4, 32'hA500_0004});
    z = int_zero_cnt;
    inta_i = 1'b1;
    wait_int_clear(z);
    drain();
    repeat (3) @(negedge clk);
    chk("ready_after_irq", 32'(cmd_ready), 32'h1);

    // Interrupt beats a pending command.
    exp_r(32'h0C);
    exp_w(32'h24, 32'h8); exp_w(32'h28, 32'h10); exp_w(32'h30, 32'h20); exp_w(32'h20, 32'h8000_0003);
    z = int_zero_cnt;
    cmd_ch = 5'd0; cmd_sz = 32'h8; cmd_a0 = 32'h10; cmd_a1 = 32'h20; cmd_csr = 32'h8000_0002;
    inta_i = 1'b1;
    cmd_valid = 1'b1;
    #1 chk("ready_low_with_inta", 32'(cmd_ready), 32'h0);
    wait_int_clear(z);
    do_cmd(5'd0, 32'h8, 32'h10, 32'h20, 32'h8000_0002);
    drain();

    // ERR on the A0 write of channel 5.
    err_at = acc_n + 1;
    exp_w(32'hC4, 32'h10); exp_w(32'hC8, 32'h3000);
    do_cmd(5'd5, 32'h10, 32'h3000, 32'h4000, 32'h4);
    drain();
    repeat (4) @(negedge clk);
    err_at = -1;
    chk("bus_err_pulses", 32'(n_err), 32'h1);
    chk("ready_after_err", 32'(cmd_ready), 32'h1);

    // Out-of-range channel.
    a = acc_n;
    r = n_rej;
    do_cmd(5'd31, 32'h1, 32'h2, 32'h3, 32'h4);
    repeat (3) @(negedge clk);
    chk("cmd_rej_pulse", 32'(n_rej - r), 32'h1);
    chk("rej_no_bus", 32'(acc_n - a), 32'h0);
    chk("ready_after_rej", 32'(cmd_ready), 32'h1);

    // Reset during a write that the slave would ACK after 3 wait cycles.
    ack_dly = 3;
    exp_w(32'h44, 32'h55);
    do_cmd(5'd1, 32'h55, 32'h66, 32'h77, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, cmd_ready, done_valid, bus_err, cmd_rej}), 32'h0);
    chk("midrst_adr", wbm_adr_o, 32'h0);
    chk("midrst_dat", wbm_dat_o, 32'h0);
    exp_acc.delete();
    rst_i = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_cyc", 32'({wbm_cyc_o, done_valid, bus_err}), 32'h0);
    chk("late_ack_ready", 32'(cmd_ready), 32'h1);
    ack_dly = 0;
    repeat (3) @(negedge clk);
    chk("late_ack_quiet", 32'({wbm_cyc_o, done_valid}), 32'h0);

    chk("total_bus_err", 32'(n_err), 32'h1);
    chk("total_cmd_rej", 32'(n_rej), 32'h1);
    chk("done_queue_empty", 32'(exp_dn.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
